ysyx_22040125_ifu: RTL and testbench
====================================

YSYX_22040125_IFU -- requirements
Module: ysyx_22040125_ifu

Interface
REQ-001 Parameter XLEN, default 64, SHALL set the PC and memory address width.
REQ-002 Parameter INST_W, default 32, SHALL set the instruction width.
REQ-003 clk  in  1  SHALL be the clock; all state updates on its rising edge.
REQ-004 rst  in  1  SHALL be the reset: synchronous, active-low.
REQ-005 cpu_pc  in  XLEN  SHALL carry the current PC from the PC register.
REQ-006 flush  in  1  SHALL signal a redirect: discard the current fetch.
REQ-007 stall  out  1  SHALL tell the PC register to hold cpu_pc.
REQ-008 mem_req_valid  out  1  SHALL flag a valid fetch request.
REQ-009 mem_req_ready  in  1  SHALL flag that memory accepts the request.
REQ-010 mem_req_addr  out  XLEN  SHALL carry the doubleword-aligned fetch address.
REQ-011 mem_rsp_valid  in  1  SHALL flag valid read data.
REQ-012 mem_rsp_data  in  64  SHALL carry the read doubleword.
REQ-013 inst_valid  out  1  SHALL flag a valid instruction to decode.
REQ-014 id_ready  in  1  SHALL flag that decode accepts the instruction.
REQ-015 inst  out  INST_W  SHALL carry the fetched instruction.
REQ-016 inst_pc  out  XLEN  SHALL carry the PC of inst.
REQ-017 inst_misalign  out  1  SHALL flag that inst_pc[1:0] != 0.

Function
REQ-018 The FSM SHALL have the states IDLE, REQ, WAIT, HOLD and DROP.
REQ-019 IDLE SHALL last exactly one cycle after reset release, then go to REQ.
REQ-020 In REQ, mem_req_valid SHALL be 1 with mem_req_addr = {cpu_pc[XLEN-1:3], 3'b000}, held stable until mem_req_ready; accept goes to WAIT.
REQ-021 REQ SHALL latch cpu_pc into an internal fetch-PC register on accept.
REQ-022 In WAIT, mem_rsp_valid SHALL capture inst = fetch_pc[2] ? data[63:32] : data[31:0] and go to HOLD.
REQ-023 mem_rsp_valid in any state other than WAIT or DROP SHALL be ignored.
REQ-024 In HOLD, inst_valid SHALL be 1 and inst/inst_pc/inst_misalign stable; id_ready goes to REQ.
REQ-025 stall SHALL be 0 only when (HOLD and id_ready) or flush, else 1; the PC advances exactly once per consumed instruction.
REQ-026 Fetch-to-decode latency SHALL be 1 cycle after response (response edge -> HOLD, inst_valid next cycle); no bypass.
REQ-027 A misaligned cpu_pc SHALL still be fetched; inst_misalign flags it, with no other special handling.
REQ-028 flush SHALL have priority over all other transitions and SHALL force inst_valid=0 in that cycle.
REQ-029 flush in IDLE, REQ without accept, or HOLD SHALL go to REQ; the unaccepted request is withdrawn.
REQ-030 flush in WAIT, or in REQ with an accept in the same cycle, SHALL go to DROP.
REQ-031 flush coinciding with mem_rsp_valid in WAIT SHALL discard the data and go to REQ.
REQ-032 DROP SHALL assert no request and discard the next mem_rsp_valid, then go to REQ; flush in DROP keeps DROP.
REQ-033 flush in HOLD with id_ready SHALL not count as a handshake; the instruction is dropped.
REQ-034 At most one request SHALL be outstanding at any time.

Reset
REQ-035 With rst=0, the block SHALL take state IDLE and drive mem_req_valid=0, inst_valid=0, stall=1, inst=0, inst_pc=0, inst_misalign=0, fetch_pc=0.
REQ-036 Reset mid-WAIT SHALL abandon the request; a late response is ignored under REQ-023.
REQ-037 Reset SHALL override flush and every handshake input.

Structure
REQ-038 The FSM state encoding, XLEN/INST_W defaults and the reset PC 64'h80000000 SHALL live in a shared package ysyx_22040125_pkg.
REQ-039 The 64-to-32 instruction select SHALL be the one natural sub-module, ysyx_22040125_inst_sel.

Verification
REQ-040 Reset release, pc=0x80000000, ready=1, response 0x00000013_00100093 after 2 cycles -> addr 0x80000000, inst 0x00100093, inst_pc 0x80000000, stall=0 for one cycle.
REQ-041 pc=0x80000004, same data -> inst 0x00000013; id_ready=0 for 3 cycles -> inst_valid held, stall=1 throughout.
REQ-042 flush in WAIT, then a response 5 cycles later -> data discarded, inst_valid never set, new request issued after the response.
REQ-043 flush coinciding with mem_rsp_valid in WAIT -> inst_valid=0, next request the following cycle, no DROP.
REQ-044 mem_req_ready=0 for 4 cycles -> mem_req_valid and addr stable; one accept yields exactly one outstanding request.
REQ-045 pc=0x80000002 -> inst_misalign=1 with inst_pc 0x80000002; rst pulsed in WAIT -> IDLE, all outputs at reset values.

Source files
------------

// File: rtl/ysyx_22040125_pkg.sv
// Shared definitions for the instruction fetch unit: widths, reset PC and FSM encoding.
package ysyx_22040125_pkg;

    localparam int          XLEN_DEF   = 64;
    localparam int          INST_W_DEF = 32;
    localparam logic [63:0] RESET_PC   = 64'h0000_0000_8000_0000;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        HOLD = 3'd3,
        DROP = 3'd4
    } ifu_state_t;

    function automatic logic misaligned(input logic [1:0] pc_lo);
        return pc_lo != 2'b00;
    endfunction

endpackage

// File: rtl/ysyx_22040125_ifu_if.sv
// Bus bundle between the fetch unit (master) and PC register, memory and decode (slave).
interface ysyx_22040125_ifu_if
    import ysyx_22040125_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int INST_W = INST_W_DEF
) ();

    // Every valid/ready pair transfers on a rising edge where both are 1; a raised
    // valid keeps its payload stable until then, and ready may depend on valid.
    logic [XLEN-1:0]   cpu_pc;
    logic              flush;
    logic              stall;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [XLEN-1:0]   mem_req_addr;
    logic              mem_rsp_valid;
    logic [63:0]       mem_rsp_data;

    logic              inst_valid;
    logic              id_ready;
    logic [INST_W-1:0] inst;
    logic [XLEN-1:0]   inst_pc;
    logic              inst_misalign;

    modport master (
        input  cpu_pc, flush, mem_req_ready, mem_rsp_valid, mem_rsp_data, id_ready,
        output stall, mem_req_valid, mem_req_addr, inst_valid, inst, inst_pc, inst_misalign
    );

    modport slave (
        output cpu_pc, flush, mem_req_ready, mem_rsp_valid, mem_rsp_data, id_ready,
        input  stall, mem_req_valid, mem_req_addr, inst_valid, inst, inst_pc, inst_misalign
    );

endinterface

// File: rtl/ysyx_22040125_inst_sel.sv
// Picks the 32-bit instruction word out of a fetched doubleword by PC bit 2.
module ysyx_22040125_inst_sel #(
    parameter int INST_W = 32
) (
    input  logic [63:0]       data,
    input  logic              upper,
    output logic [INST_W-1:0] inst
);

    assign inst = upper ? data[32 +: INST_W] : data[0 +: INST_W];

endmodule

// File: rtl/ysyx_22040125_ifu.sv
// Single-outstanding instruction fetch unit: PC -> memory request -> response -> decode hold.
module ysyx_22040125_ifu
    import ysyx_22040125_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int INST_W = INST_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    ysyx_22040125_ifu_if.master bus,
    output ifu_state_t          dbg_state
);

    ifu_state_t        state;
    ifu_state_t        state_next;
    logic              req_accept;
    logic              rsp_capture;
    logic [XLEN-1:0]   fetch_pc;
    logic [INST_W-1:0] sel_inst;
    logic [INST_W-1:0] inst_r;
    logic [XLEN-1:0]   inst_pc_r;
    logic              misalign_r;

    ysyx_22040125_inst_sel #(.INST_W(INST_W)) u_inst_sel (
        .data  (bus.mem_rsp_data),
        .upper (fetch_pc[2]),
        .inst  (sel_inst)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            fetch_pc   <= '0;
            inst_r     <= '0;
            inst_pc_r  <= '0;
            misalign_r <= 1'b0;
        end else begin
            state <= state_next;
            if (req_accept) begin
                fetch_pc <= bus.cpu_pc;
            end
            if (rsp_capture) begin
                inst_r     <= sel_inst;
                inst_pc_r  <= fetch_pc;
                misalign_r <= misaligned(fetch_pc[1:0]);
            end
        end
    end

    always_comb begin
        state_next  = state;
        req_accept  = 1'b0;
        rsp_capture = 1'b0;
        case (state)
            IDLE: state_next = REQ;
            REQ: begin
                req_accept = bus.mem_req_ready;
                // An accepted request is owed a response even when flushed, so DROP absorbs it.
                if (bus.flush) begin
                    state_next = bus.mem_req_ready ? DROP : REQ;
                end else if (bus.mem_req_ready) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (bus.flush) begin
                    state_next = bus.mem_rsp_valid ? REQ : DROP;
                end else if (bus.mem_rsp_valid) begin
                    rsp_capture = 1'b1;
                    state_next  = HOLD;
                end
            end
            HOLD: begin
                if (bus.flush || bus.id_ready) begin
                    state_next = REQ;
                end
            end
            DROP: begin
                // A flush alone keeps waiting; a response in the same cycle still retires the request.
                if (bus.mem_rsp_valid) begin
                    state_next = REQ;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.mem_req_valid = rst && (state == REQ);
    assign bus.mem_req_addr  = {bus.cpu_pc[XLEN-1:3], 3'b000};
    assign bus.inst_valid    = rst && (state == HOLD) && !bus.flush;
    assign bus.stall         = !(rst && (((state == HOLD) && bus.id_ready) || bus.flush));
    assign bus.inst          = inst_r;
    assign bus.inst_pc       = inst_pc_r;
    assign bus.inst_misalign = misalign_r;
    assign dbg_state         = state;

endmodule

// File: tb/tb_ysyx_22040125_ifu.sv
// Self-checking bench for ysyx_22040125_ifu: vector table, flush/reset sequences, scoreboard queue.
module tb_ysyx_22040125_ifu;
    import ysyx_22040125_pkg::*;

    localparam int XLEN   = 64;
    localparam int INST_W = 32;
    localparam int EW     = 1 + XLEN + INST_W;

    typedef struct {
        logic [63:0] pc;
        logic [63:0] data;
        int          rw;
        int          rd;
        int          hold;
        logic [31:0] e_inst;
        logic [63:0] e_addr;
        logic        e_mis;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    ifu_state_t dbg_state;
    int         checks = 0;
    int         errors = 0;
    logic [EW-1:0] exp_q[$];
    vec_t       vecs[6];

    ysyx_22040125_ifu_if #(.XLEN(XLEN), .INST_W(INST_W)) bus ();

    ysyx_22040125_ifu #(.XLEN(XLEN), .INST_W(INST_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time %0t reached, expected finish earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.flush         = 1'b0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.id_ready      = 1'b0;
    endtask

    task automatic consume(input string tag);
        logic [EW-1:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s.scoreboard: got inst %h with queue empty, expected no instruction", tag, bus.inst);
        end else begin
            e = exp_q.pop_front();
            check($sformatf("%s.inst", tag), 64'(bus.inst), 64'(e[INST_W-1:0]));
            check($sformatf("%s.inst_pc", tag), bus.inst_pc, e[INST_W +: XLEN]);
            check($sformatf("%s.misalign", tag), 64'(bus.inst_misalign), 64'(e[EW-1]));
        end
    endtask

    // Starts and ends just after a rising edge; reset is held while every handshake input is active.
    task automatic do_reset();
        rst               = 1'b0;
        bus.flush         = 1'b1;
        bus.mem_req_ready = 1'b1;
        bus.mem_rsp_valid = 1'b1;
        bus.id_ready      = 1'b1;
        step();
        step();
        sample();
        check("rst.state", 64'(dbg_state), 64'(IDLE));
        check("rst.req_valid", 64'(bus.mem_req_valid), 64'd0);
        check("rst.inst_valid", 64'(bus.inst_valid), 64'd0);
        check("rst.stall", 64'(bus.stall), 64'd1);
        check("rst.inst", 64'(bus.inst), 64'd0);
        check("rst.inst_pc", bus.inst_pc, 64'd0);
        check("rst.misalign", 64'(bus.inst_misalign), 64'd0);
        step();
        idle_inputs();
        exp_q.delete();
        rst = 1'b1;
        sample();
        check("rel.state_idle", 64'(dbg_state), 64'(IDLE));
        check("rel.req_valid", 64'(bus.mem_req_valid), 64'd0);
        step();
        sample();
        check("rel.state_req", 64'(dbg_state), 64'(REQ));
        step();
    endtask

    // Full fetch starting in REQ: rw cycles of ready low, rd WAIT cycles, hold cycles of id_ready low.
    task automatic fetch(input vec_t v, input string tag);
        bus.cpu_pc        = v.pc;
        bus.mem_req_ready = 1'b0;
        for (int i = 0; i < v.rw; i++) begin
            sample();
            check($sformatf("%s.req_valid_w", tag), 64'(bus.mem_req_valid), 64'd1);
            check($sformatf("%s.addr_w", tag), bus.mem_req_addr, v.e_addr);
            check($sformatf("%s.stall_req", tag), 64'(bus.stall), 64'd1);
            step();
        end
        bus.mem_req_ready = 1'b1;
        sample();
        check($sformatf("%s.req_valid", tag), 64'(bus.mem_req_valid), 64'd1);
        check($sformatf("%s.addr", tag), bus.mem_req_addr, v.e_addr);
        step();
        bus.mem_req_ready = 1'b0;
        bus.cpu_pc        = v.pc ^ 64'h100;
        for (int i = 0; i < v.rd; i++) begin
            sample();
            check($sformatf("%s.one_outstanding", tag), 64'(bus.mem_req_valid), 64'd0);
            check($sformatf("%s.wait_inst_valid", tag), 64'(bus.inst_valid), 64'd0);
            step();
        end
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = v.data;
        exp_q.push_back({v.e_mis, v.pc, v.e_inst});
        sample();
        check($sformatf("%s.no_bypass", tag), 64'(bus.inst_valid), 64'd0);
        step();
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = {$urandom, $urandom};
        for (int i = 0; i < v.hold; i++) begin
            sample();
            check($sformatf("%s.held_valid", tag), 64'(bus.inst_valid), 64'd1);
            check($sformatf("%s.held_stall", tag), 64'(bus.stall), 64'd1);
            check($sformatf("%s.held_inst", tag), 64'(bus.inst), 64'(v.e_inst));
            step();
        end
        bus.id_ready = 1'b1;
        sample();
        check($sformatf("%s.inst_valid", tag), 64'(bus.inst_valid), 64'd1);
        check($sformatf("%s.stall_release", tag), 64'(bus.stall), 64'd0);
        if (bus.inst_valid && bus.id_ready) consume(tag);
        step();
        bus.id_ready = 1'b0;
        sample();
        check($sformatf("%s.next_req", tag), 64'(dbg_state), 64'(REQ));
        check($sformatf("%s.stall_after", tag), 64'(bus.stall), 64'd1);
        step();
    endtask

    task automatic seq_flush_wait();
        bus.cpu_pc        = 64'h8000_0010;
        bus.mem_req_ready = 1'b1;
        step();
        bus.mem_req_ready = 1'b0;
        bus.flush         = 1'b1;
        bus.cpu_pc        = 64'h8000_0100;
        sample();
        check("fw.flush_stall", 64'(bus.stall), 64'd0);
        check("fw.flush_inst_valid", 64'(bus.inst_valid), 64'd0);
        step();
        bus.flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sample();
            check("fw.drop_state", 64'(dbg_state), 64'(DROP));
            check("fw.drop_no_req", 64'(bus.mem_req_valid), 64'd0);
            check("fw.drop_inst_valid", 64'(bus.inst_valid), 64'd0);
            step();
        end
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 64'hFFFF_EEEE_DDDD_CCCC;
        sample();
        check("fw.late_no_req", 64'(bus.mem_req_valid), 64'd0);
        check("fw.late_inst_valid", 64'(bus.inst_valid), 64'd0);
        step();
        bus.mem_rsp_valid = 1'b0;
        sample();
        check("fw.new_req", 64'(bus.mem_req_valid), 64'd1);
        check("fw.new_addr", bus.mem_req_addr, 64'h8000_0100);
        check("fw.new_inst_valid", 64'(bus.inst_valid), 64'd0);
        step();
    endtask

    task automatic seq_flush_rsp();
        bus.cpu_pc        = 64'h8000_0020;
        bus.mem_req_ready = 1'b1;
        step();
        bus.mem_req_ready = 1'b0;
        bus.flush         = 1'b1;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 64'h1111_2222_3333_4444;
        bus.cpu_pc        = 64'h8000_0200;
        sample();
        check("fr.inst_valid", 64'(bus.inst_valid), 64'd0);
        check("fr.stall", 64'(bus.stall), 64'd0);
        step();
        idle_inputs();
        sample();
        check("fr.state_req", 64'(dbg_state), 64'(REQ));
        check("fr.req_valid", 64'(bus.mem_req_valid), 64'd1);
        check("fr.addr", bus.mem_req_addr, 64'h8000_0200);
        step();
    endtask

    task automatic seq_flush_req_hold();
        bus.cpu_pc = 64'h8000_0300;
        bus.flush  = 1'b1;
        sample();
        check("fq.withdraw_stall", 64'(bus.stall), 64'd0);
        step();
        bus.flush  = 1'b0;
        bus.cpu_pc = 64'h8000_0308;
        sample();
        check("fq.stay_req", 64'(dbg_state), 64'(REQ));
        check("fq.addr", bus.mem_req_addr, 64'h8000_0308);
        bus.mem_req_ready = 1'b1;
        bus.flush         = 1'b1;
        step();
        idle_inputs();
        sample();
        check("fq.accept_drop", 64'(dbg_state), 64'(DROP));
        check("fq.drop_no_req", 64'(bus.mem_req_valid), 64'd0);
        step();
        bus.mem_rsp_valid = 1'b1;
        step();
        bus.mem_rsp_valid = 1'b0;
        sample();
        check("fq.drop_to_req", 64'(dbg_state), 64'(REQ));
        bus.cpu_pc        = 64'h8000_0400;
        bus.mem_req_ready = 1'b1;
        step();
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 64'h1234_5678_9ABC_DEF0;
        step();
        bus.mem_rsp_valid = 1'b0;
        sample();
        check("fh.hold_valid", 64'(bus.inst_valid), 64'd1);
        check("fh.hold_inst", 64'(bus.inst), 64'h9ABC_DEF0);
        bus.id_ready = 1'b1;
        bus.flush    = 1'b1;
        bus.cpu_pc   = 64'h8000_0500;
        step();
        idle_inputs();
        sample();
        check("fh.state_req", 64'(dbg_state), 64'(REQ));
        check("fh.addr", bus.mem_req_addr, 64'h8000_0500);
        step();
    endtask

    task automatic seq_reset_wait();
        bus.cpu_pc        = 64'h8000_0600;
        bus.mem_req_ready = 1'b1;
        step();
        bus.mem_req_ready = 1'b0;
        rst               = 1'b0;
        step();
        rst               = 1'b1;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 64'h5555_6666_7777_8888;
        sample();
        check("rw.state", 64'(dbg_state), 64'(IDLE));
        check("rw.req_valid", 64'(bus.mem_req_valid), 64'd0);
        check("rw.inst_valid", 64'(bus.inst_valid), 64'd0);
        check("rw.stall", 64'(bus.stall), 64'd1);
        check("rw.inst", 64'(bus.inst), 64'd0);
        check("rw.inst_pc", bus.inst_pc, 64'd0);
        check("rw.misalign", 64'(bus.inst_misalign), 64'd0);
        step();
        bus.mem_rsp_valid = 1'b0;
        sample();
        check("rw.late_state", 64'(dbg_state), 64'(REQ));
        check("rw.late_inst_valid", 64'(bus.inst_valid), 64'd0);
        step();
    endtask

    initial begin
        vec_t rv;
        bus.cpu_pc       = RESET_PC;
        bus.mem_rsp_data = '0;
        idle_inputs();

        vecs[0] = '{64'h8000_0000, 64'h0000_0013_0010_0093, 0, 2, 0, 32'h0010_0093, 64'h8000_0000, 1'b0};
        vecs[1] = '{64'h8000_0004, 64'h0000_0013_0010_0093, 0, 1, 3, 32'h0000_0013, 64'h8000_0000, 1'b0};
        vecs[2] = '{64'h8000_0002, 64'h1111_1111_2222_2222, 1, 0, 1, 32'h2222_2222, 64'h8000_0000, 1'b1};
        vecs[3] = '{64'h8000_1238, 64'hDEAD_BEEF_CAFE_F00D, 4, 0, 0, 32'hCAFE_F00D, 64'h8000_1238, 1'b0};
        vecs[4] = '{64'h8000_123C, 64'hDEAD_BEEF_CAFE_F00D, 0, 3, 2, 32'hDEAD_BEEF, 64'h8000_1238, 1'b0};
        vecs[5] = '{64'h8000_0007, 64'hAAAA_5555_1234_5678, 2, 1, 0, 32'hAAAA_5555, 64'h8000_0000, 1'b1};

        step();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            fetch(vecs[i], $sformatf("vec%0d", i));
        end

        seq_flush_wait();
        seq_flush_rsp();
        seq_flush_req_hold();

        for (int i = 0; i < 6; i++) begin
            rv.pc     = RESET_PC + 64'($urandom_range(0, 4095));
            rv.data   = {$urandom, $urandom};
            rv.rw     = $urandom_range(0, 3);
            rv.rd     = $urandom_range(0, 3);
            rv.hold   = $urandom_range(0, 2);
            rv.e_inst = rv.pc[2] ? rv.data[63:32] : rv.data[31:0];
            rv.e_addr = {rv.pc[63:3], 3'b000};
            rv.e_mis  = rv.pc[1:0] != 2'b00;
            fetch(rv, $sformatf("rnd%0d", i));
        end

        seq_reset_wait();
        fetch(vecs[0], "post_rst");

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
